// File: rtl/sdf_pkg.sv
// Shared definitions for the R2SDF FFT stage controllers: FSM state encoding
// and the frame-counter width helper.
package sdf_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } sdf_state_e;

  // Counter spans one stage frame of 2*delay samples.
  function automatic int cnt_width(input int delay);
    return $clog2(2 * delay);
  endfunction

endpackage

// File: rtl/sdf_stage_controller.sv
// Sequencer for one radix-2 single-path delay-feedback FFT stage: counts the
// 2*delay-sample frame and drives butterfly select, twiddle address and output framing.
module sdf_stage_controller
  import sdf_pkg::*;
#(
  parameter int delay     = 8,
  parameter int tw_stride = 1,
  parameter int tw_width  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic                in_sop,
  output logic                bf_sel,
  output logic [tw_width-1:0] tw_addr,
  output logic                out_valid,
  output logic                out_sop,
  output logic                out_eop,
  output logic                err
);

  localparam int CW = cnt_width(delay);
  localparam int AW = $clog2(delay);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(delay - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(delay);

  sdf_state_e          state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                valid_c;
  logic                bf_c;
  logic                abort_c;
  logic [tw_width-1:0] tw_prod;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_c = 1'b0;
    bf_c    = 1'b0;
    abort_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_sop) begin
            state_d = FILL;
            cnt_d   = CNT_ONE;
          end else begin
            abort_c = 1'b1;
          end
        end
      end
      FILL: begin
        // cnt never returns to 0 while filling, so any in_sop here is misplaced.
        if (!in_valid || in_sop) begin
          abort_c = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) state_d = RUN;
        end
      end
      RUN: begin
        if (in_valid) begin
          if (in_sop && cnt_q != '0) begin
            abort_c = 1'b1;
          end else begin
            valid_c = 1'b1;
            bf_c    = cnt_q[CW-1];
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else if (cnt_q == '0) begin
          valid_c = 1'b1;
          state_d = FLUSH;
          cnt_d   = CNT_ONE;
        end else begin
          abort_c = 1'b1;
        end
      end
      FLUSH: begin
        if (in_valid) begin
          abort_c = 1'b1;
        end else begin
          valid_c = 1'b1;
          cnt_d   = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A violation drops the sample and silences the outputs for this cycle.
    if (abort_c) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
    err_d = abort_c;
  end

  always_comb begin
    tw_prod   = tw_width'(32'(cnt_q[AW-1:0]) * tw_stride);
    bf_sel    = bf_c;
    out_valid = valid_c;
    tw_addr   = (valid_c && !bf_c) ? tw_prod : '0;
    out_sop   = valid_c && (cnt_q == CNT_MID);
    out_eop   = valid_c && (cnt_q == CNT_LAST) && (state_q != FILL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_sdf_stage_controller.sv
// Scoreboard bench for sdf_stage_controller: directed frame scenarios plus random
// streams, checked against a sample-position reference model.
module tb_sdf_stage_controller;

  localparam int D      = 4;
  localparam int STRIDE = 1;
  localparam int TW     = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_sop = 1'b0;
  logic          bf_sel, out_valid, out_sop, out_eop, err;
  logic [TW-1:0] tw_addr;

  sdf_stage_controller #(
    .delay    (D),
    .tw_stride(STRIDE),
    .tw_width (TW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_sop   (in_sop),
    .bf_sel   (bf_sel),
    .tw_addr  (tw_addr),
    .out_valid(out_valid),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int bf;
    int tw;
    int sop;
    int eop;
  } exp_t;

  exp_t out_q[$];
  int   err_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   cur_cyc = 0;
  bit   mon_en = 1'b0;

  // Reference model: position of the next input sample within its frame,
  // whether the first half-frame has been collected, and the flush index.
  bit   m_busy = 1'b0;
  bit   m_primed = 1'b0;
  int   m_pos = 0;
  int   m_flush = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_total++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cur_cyc, act, exp_v);
  endtask

  task automatic model(input bit v, input bit s, input bit r);
    exp_t e;
    bit   ov, viol;
    ov = 0; viol = 0;
    e.cyc = cur_cyc; e.bf = 0; e.tw = 0; e.sop = 0; e.eop = 0;
    if (m_flush != 0) begin
      if (v) viol = 1;
      else begin
        ov    = 1;
        e.tw  = m_flush * STRIDE;
        e.eop = (m_flush == D - 1);
        m_flush = (m_flush == D - 1) ? 0 : m_flush + 1;
      end
    end else if (m_busy) begin
      if (v && s && m_pos != 0) viol = 1;
      else if (v) begin
        ov    = m_primed;
        e.bf  = ov && (m_pos >= D);
        e.tw  = (ov && m_pos < D) ? m_pos * STRIDE : 0;
        e.sop = ov && (m_pos == D);
        e.eop = ov && (m_pos == D - 1);
        m_pos = (m_pos + 1) % (2 * D);
        if (m_pos == D) m_primed = 1;
      end else if (m_primed && m_pos == 0) begin
        ov      = 1;
        m_busy  = 0;
        m_flush = 1;
      end else viol = 1;
    end else if (v) begin
      if (s) begin
        m_busy   = 1;
        m_pos    = 1;
        m_primed = 0;
      end else viol = 1;
    end
    if (viol) begin
      m_busy  = 0;
      m_flush = 0;
      if (!r) err_q.push_back(cur_cyc + 1);
    end
    if (r) begin
      m_busy  = 0;
      m_flush = 0;
    end
    if (ov) out_q.push_back(e);
  endtask

  task automatic step(input bit v, input bit s, input bit r);
    in_valid = v;
    in_sop   = s;
    rst      = r;
    cur_cyc  = cyc;
    model(v, s, r);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n * 2 * D; i++) step(1'b1, (i % (2 * D)) == 0, 1'b0);
  endtask

  exp_t mon_e;
  bit   mon_exp_err;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_exp_err = 1'b0;
      if (err_q.size() > 0 && err_q[0] == cur_cyc) begin
        mon_exp_err = 1'b1;
        void'(err_q.pop_front());
      end
      chk("err", int'(err), int'(mon_exp_err));
      if (out_q.size() > 0 && out_q[0].cyc == cur_cyc) begin
        mon_e = out_q.pop_front();
        chk("out_valid", int'(out_valid), 1);
        if (out_valid) begin
          chk("bf_sel", int'(bf_sel), mon_e.bf);
          chk("tw_addr", int'(tw_addr), mon_e.tw);
          chk("out_sop", int'(out_sop), mon_e.sop);
          chk("out_eop", int'(out_eop), mon_e.eop);
          $display("cyc %0d out bf=%0d tw=%0d sop=%0d eop=%0d",
                   cur_cyc, bf_sel, tw_addr, out_sop, out_eop);
        end
      end else begin
        chk("spurious_out_valid", int'(out_valid), 0);
        chk("idle_outputs", int'({bf_sel, tw_addr, out_sop, out_eop}), 0);
      end
    end
  end

  int kind, nf, at, how, len;
  bit inj, v, s;

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;

    // single frame, then back-to-back pair
    gap(2);
    frames(1); gap(2 * D);
    frames(2); gap(2 * D);
    // gap mid-frame, then stray valid without sop
    step(1, 1, 0); repeat (4) step(1, 0, 0); step(0, 0, 0); gap(2);
    step(1, 0, 0); gap(3);
    // misplaced sop, then clean restart
    step(1, 1, 0); step(1, 0, 0); step(1, 1, 0); gap(2);
    frames(1); gap(2 * D);
    // valid during flush
    frames(1); step(0, 0, 0); step(1, 0, 0); gap(2 * D);
    // reset mid-frame, stream continues without sop
    step(1, 1, 0); repeat (5) step(1, 0, 0); step(1, 0, 1);
    repeat (5) step(1, 0, 0); gap(3);

    for (int k = 0; k < 300; k++) begin
      kind = $urandom_range(0, 9);
      if (kind < 5) begin
        nf  = $urandom_range(1, 3);
        inj = ($urandom_range(0, 5) == 0);
        at  = $urandom_range(0, nf * 2 * D - 1);
        how = $urandom_range(0, 1);
        for (int i = 0; i < nf * 2 * D; i++) begin
          v = 1'b1;
          s = (i % (2 * D)) == 0;
          if (inj && i == at) begin
            if (how == 1) v = 1'b0;
            else s = ~s;
          end
          step(v, s, 1'b0);
        end
      end else if (kind < 8) begin
        gap($urandom_range(0, 3 * D));
      end else if (kind == 8) begin
        len = $urandom_range(1, 3);
        for (int i = 0; i < len; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      end else begin
        step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
      end
    end
    gap(3 * D);

    chk("out_queue_drained", out_q.size(), 0);
    chk("err_queue_drained", err_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
